// File: rtl/vc_domain_demux2_queue_pkg.sv
// Shared definitions for the domain-labelled 1-to-2 demux and its queues.
package vc_domain_demux2_queue_pkg;

  // Security domain labels, lowest to highest.
  typedef logic [1:0] domain_t;
  localparam domain_t DOM_LOW  = 2'b00;
  localparam domain_t DOM_1    = 2'b01;
  localparam domain_t DOM_2    = 2'b10;
  localparam domain_t DOM_HIGH = 2'b11;

  // Per-output queue geometry: two entries, occupancy counts 0..2.
  localparam int unsigned QUEUE_DEPTH = 2;
  localparam int unsigned COUNT_W     = 2;
  typedef logic [COUNT_W-1:0] count_t;

  // One-bit pointers simply toggle, wrapping 1 -> 0.
  function automatic logic ptr_next(input logic ptr);
    return ~ptr;
  endfunction

endpackage

// File: rtl/vc_domain_queue2.sv
// Two-entry labelled queue. Entries are scrubbed to zero as they are
// dequeued so a freed slot never holds a stale payload or label.
module vc_domain_queue2
  import vc_domain_demux2_queue_pkg::*;
#(
  parameter int p_nbits = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enq_val_i,
  input  logic [p_nbits-1:0] enq_msg_i,
  input  domain_t            enq_domain_i,
  output logic               full_o,
  output logic               deq_val_o,
  input  logic               deq_rdy_i,
  output logic [p_nbits-1:0] deq_msg_o,
  output domain_t            deq_domain_o
);

  logic [p_nbits-1:0] msg_q [QUEUE_DEPTH];
  logic [p_nbits-1:0] msg_d [QUEUE_DEPTH];
  domain_t            dom_q [QUEUE_DEPTH];
  domain_t            dom_d [QUEUE_DEPTH];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  count_t             count_q, count_d;
  logic               enq_fire;
  logic               deq_fire;

  assign full_o    = (count_q == count_t'(QUEUE_DEPTH));
  assign deq_val_o = (count_q != '0);
  assign enq_fire  = enq_val_i && !full_o;
  assign deq_fire  = deq_val_o && deq_rdy_i;

  // Head is forced to zero when empty, independent of entry contents.
  assign deq_msg_o    = deq_val_o ? msg_q[rd_ptr_q] : '0;
  assign deq_domain_o = deq_val_o ? dom_q[rd_ptr_q] : DOM_LOW;

  // Next-state: scrub the vacated head on dequeue, write the tail on enqueue.
  // With one entry present the two slots differ, so both can act together.
  always_comb begin
    msg_d    = msg_q;
    dom_d    = dom_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (deq_fire) begin
      msg_d[rd_ptr_q] = '0;
      dom_d[rd_ptr_q] = DOM_LOW;
      rd_ptr_d        = ptr_next(rd_ptr_q);
    end
    if (enq_fire) begin
      msg_d[wr_ptr_q] = enq_msg_i;
      dom_d[wr_ptr_q] = enq_domain_i;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + count_t'(1);
      2'b01:   count_d = count_q - count_t'(1);
      default: count_d = count_q;
    endcase
  end

  // State register; reset discards all stored data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        msg_q[i] <= '0;
        dom_q[i] <= DOM_LOW;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      msg_q    <= msg_d;
      dom_q    <= dom_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vc_domain_demux2_queue.sv
// Domain-labelled 1-to-2 demux: steers each input message into the queue
// chosen by the public select. in_rdy reflects only the selected queue's
// occupancy; there is no bypass from the consumers' ready signals.
module vc_domain_demux2_queue
  import vc_domain_demux2_queue_pkg::*;
#(
  parameter int p_nbits = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_msg,
  input  domain_t            in_domain,
  input  logic               sel,
  output logic               out0_val,
  input  logic               out0_rdy,
  output logic [p_nbits-1:0] out0_msg,
  output domain_t            out0_domain,
  output logic               out1_val,
  input  logic               out1_rdy,
  output logic [p_nbits-1:0] out1_msg,
  output domain_t            out1_domain
);

  logic full0, full1;
  logic enq0, enq1;

  // Steering and ready mux.
  always_comb begin
    enq0   = in_val && !sel;
    enq1   = in_val &&  sel;
    in_rdy = sel ? !full1 : !full0;
  end

  vc_domain_queue2 #(.p_nbits(p_nbits)) u_q0 (
    .clk          (clk),
    .reset_n      (reset_n),
    .enq_val_i    (enq0),
    .enq_msg_i    (in_msg),
    .enq_domain_i (in_domain),
    .full_o       (full0),
    .deq_val_o    (out0_val),
    .deq_rdy_i    (out0_rdy),
    .deq_msg_o    (out0_msg),
    .deq_domain_o (out0_domain)
  );

  vc_domain_queue2 #(.p_nbits(p_nbits)) u_q1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .enq_val_i    (enq1),
    .enq_msg_i    (in_msg),
    .enq_domain_i (in_domain),
    .full_o       (full1),
    .deq_val_o    (out1_val),
    .deq_rdy_i    (out1_rdy),
    .deq_msg_o    (out1_msg),
    .deq_domain_o (out1_domain)
  );

endmodule

// File: tb/tb_vc_domain_demux2_queue.sv
// Directed bench for the domain-labelled 1-to-2 demux queue.
module tb_vc_domain_demux2_queue;

  logic       clk;
  logic       reset_n;
  logic       in_val;
  logic       in_rdy;
  logic [7:0] in_msg;
  logic [1:0] in_domain;
  logic       sel;
  logic       out0_val, out0_rdy;
  logic [7:0] out0_msg;
  logic [1:0] out0_domain;
  logic       out1_val, out1_rdy;
  logic [7:0] out1_msg;
  logic [1:0] out1_domain;

  int tests_run = 0;
  int tests_failed = 0;

  vc_domain_demux2_queue #(.p_nbits(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_val      (in_val),
    .in_rdy      (in_rdy),
    .in_msg      (in_msg),
    .in_domain   (in_domain),
    .sel         (sel),
    .out0_val    (out0_val),
    .out0_rdy    (out0_rdy),
    .out0_msg    (out0_msg),
    .out0_domain (out0_domain),
    .out1_val    (out1_val),
    .out1_rdy    (out1_rdy),
    .out1_msg    (out1_msg),
    .out1_domain (out1_domain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       in_val;
    logic       sel;
    logic [7:0] msg;
    logic [1:0] dom;
    logic       o0_rdy;
    logic       o1_rdy;
    logic       e_in_rdy;
    logic       e0_val;
    logic [7:0] e0_msg;
    logic [1:0] e0_dom;
    logic       e1_val;
    logic [7:0] e1_msg;
    logic [1:0] e1_dom;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(input logic v, input logic s, input logic [7:0] m,
                              input logic [1:0] d, input logic r0, input logic r1,
                              input logic eir, input logic e0v, input logic [7:0] e0m,
                              input logic [1:0] e0d, input logic e1v,
                              input logic [7:0] e1m, input logic [1:0] e1d);
    vec_t t;
    t.in_val = v;  t.sel = s;  t.msg = m;  t.dom = d;
    t.o0_rdy = r0; t.o1_rdy = r1; t.e_in_rdy = eir;
    t.e0_val = e0v; t.e0_msg = e0m; t.e0_dom = e0d;
    t.e1_val = e1v; t.e1_msg = e1m; t.e1_dom = e1d;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] m,
                       input logic [1:0] d, input logic r0, input logic r1);
    in_val = v; sel = s; in_msg = m; in_domain = d; out0_rdy = r0; out1_rdy = r1;
  endtask

  int sent;
  int rcvd;

  initial begin
    drive(0, 0, 8'h00, 2'b00, 0, 0);
    reset_n = 1'b0;
    #12;
    // Reset state before release.
    check("rst_in_rdy", in_rdy, 1);
    check("rst_out0_val", out0_val, 0);
    check("rst_out1_val", out1_val, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Columns: in_val sel msg dom rdy0 rdy1 | in_rdy | out0 v/m/d | out1 v/m/d
    // Expected outputs are those seen before the edge that applies the row.
    vecs[0]  = mk(0, 0, 8'h00, 2'd0, 0, 0,  1,  0, 8'h00, 2'd0,  0, 8'h00, 2'd0);
    vecs[1]  = mk(1, 0, 8'hA5, 2'd1, 0, 0,  1,  0, 8'h00, 2'd0,  0, 8'h00, 2'd0);
    vecs[2]  = mk(1, 1, 8'h3C, 2'd2, 0, 0,  1,  1, 8'hA5, 2'd1,  0, 8'h00, 2'd0);
    vecs[3]  = mk(1, 0, 8'h11, 2'd3, 0, 0,  1,  1, 8'hA5, 2'd1,  1, 8'h3C, 2'd2);
    vecs[4]  = mk(1, 0, 8'h22, 2'd0, 0, 0,  0,  1, 8'hA5, 2'd1,  1, 8'h3C, 2'd2);
    vecs[5]  = mk(1, 1, 8'h22, 2'd0, 0, 0,  1,  1, 8'hA5, 2'd1,  1, 8'h3C, 2'd2);
    vecs[6]  = mk(1, 0, 8'h44, 2'd1, 1, 0,  0,  1, 8'hA5, 2'd1,  1, 8'h3C, 2'd2);
    vecs[7]  = mk(0, 0, 8'h00, 2'd0, 0, 1,  1,  1, 8'h11, 2'd3,  1, 8'h3C, 2'd2);
    vecs[8]  = mk(1, 0, 8'h55, 2'd2, 1, 1,  1,  1, 8'h11, 2'd3,  1, 8'h22, 2'd0);
    vecs[9]  = mk(0, 1, 8'h00, 2'd0, 1, 1,  1,  1, 8'h55, 2'd2,  0, 8'h00, 2'd0);
    vecs[10] = mk(0, 0, 8'h00, 2'd0, 0, 0,  1,  0, 8'h00, 2'd0,  0, 8'h00, 2'd0);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].in_val, vecs[i].sel, vecs[i].msg, vecs[i].dom,
            vecs[i].o0_rdy, vecs[i].o1_rdy);
      #1;
      check($sformatf("v%0d_in_rdy", i),   in_rdy,      vecs[i].e_in_rdy);
      check($sformatf("v%0d_out0_val", i), out0_val,    vecs[i].e0_val);
      check($sformatf("v%0d_out0_msg", i), out0_msg,    vecs[i].e0_msg);
      check($sformatf("v%0d_out0_dom", i), out0_domain, vecs[i].e0_dom);
      check($sformatf("v%0d_out1_val", i), out1_val,    vecs[i].e1_val);
      check($sformatf("v%0d_out1_msg", i), out1_msg,    vecs[i].e1_msg);
      check($sformatf("v%0d_out1_dom", i), out1_domain, vecs[i].e1_dom);
      tick();
    end

    // Every slot has been used and drained: storage must be scrubbed.
    check("scrub_q0_msg0", dut.u_q0.msg_q[0], 0);
    check("scrub_q0_msg1", dut.u_q0.msg_q[1], 0);
    check("scrub_q0_dom0", dut.u_q0.dom_q[0], 0);
    check("scrub_q0_dom1", dut.u_q0.dom_q[1], 0);
    check("scrub_q1_msg0", dut.u_q1.msg_q[0], 0);
    check("scrub_q1_msg1", dut.u_q1.msg_q[1], 0);

    // Single message in and out, then the head must read as empty zeros.
    drive(1, 0, 8'hC3, 2'd3, 0, 0);
    tick();
    drive(0, 0, 8'h00, 2'd0, 1, 0);
    #1;
    check("scrub_pre_val", out0_val, 1);
    check("scrub_pre_msg", out0_msg, 8'hC3);
    tick();
    check("scrub_out0_val", out0_val, 0);
    check("scrub_out0_msg", out0_msg, 0);
    check("scrub_out0_dom", out0_domain, 0);
    check("scrub_entry", dut.u_q0.msg_q[0] | dut.u_q0.msg_q[1], 0);

    // Stream 0..7 through out0 with random consumer stalls.
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 300 && rcvd < 8; cyc++) begin
      drive(sent < 8, 0, 8'(sent), 2'(sent), 1'($urandom_range(0, 1)), 0);
      #1;
      if (out0_val && out0_rdy) begin
        check("order_msg", out0_msg, rcvd);
        check("order_dom", out0_domain, rcvd % 4);
        rcvd++;
      end
      if (in_val && in_rdy) sent++;
      tick();
    end
    check("order_count", rcvd, 8);
    drive(0, 0, 8'h00, 2'd0, 0, 0);
    #1;
    check("order_drained", out0_val, 0);

    // Fill both queues, then assert reset mid-cycle.
    drive(1, 0, 8'h01, 2'd1, 0, 0); tick();
    drive(1, 0, 8'h02, 2'd2, 0, 0); tick();
    drive(1, 1, 8'h03, 2'd3, 0, 0); tick();
    drive(1, 1, 8'h04, 2'd1, 0, 0); tick();
    drive(1, 0, 8'h05, 2'd1, 0, 0);
    #1;
    check("full_in_rdy_sel0", in_rdy, 0);
    sel = 1'b1;
    #1;
    check("full_in_rdy_sel1", in_rdy, 0);
    check("full_out1_msg", out1_msg, 8'h03);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_in_rdy", in_rdy, 1);
    check("arst_out0_val", out0_val, 0);
    check("arst_out1_val", out1_val, 0);
    check("arst_out0_msg", out0_msg, 0);
    check("arst_out1_msg", out1_msg, 0);
    check("arst_out0_dom", out0_domain, 0);
    check("arst_out1_dom", out1_domain, 0);
    check("arst_entry", dut.u_q1.msg_q[0] | dut.u_q1.msg_q[1], 0);
    drive(0, 0, 8'h00, 2'd0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_rst_out0_val", out0_val, 0);
    check("post_rst_out1_val", out1_val, 0);
    check("post_rst_in_rdy", in_rdy, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
